conv_systolic_engine: RTL and testbench
=======================================

Name: conv_systolic_engine

Overview:
- Parametrised, self-sequenced convolution engine built around an N x N output-stationary systolic MAC array.
- Computes C = A(N x K) * B(K x N): A rows are im2col input patches, B columns are N filters.
- Operands stream in over a valid/ready port into internal operand buffers; an internal FSM generates the skewed feeds, then streams the N*N saturated results out.
- Replaces external address-driven muxing and the fixed 2x2 array with one block driven only by start and handshakes.

Parameters:
- N, 2, array dimension: output rows, filter count.
- K, 9, reduction length (e.g. 3x3 kernel).
- DATA_W, 8, unsigned operand width.
- ACC_W, 20, accumulator width; elaboration error if ACC_W < 2*DATA_W + clog2(K).
- OUT_W, 8, result width.
- SHIFT, 0, right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final output handshake.
- in_valid  in  1  operand word valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  DATA_W  operand word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  OUT_W  saturated result.
- out_idx  out  clog2(N*N)  result index, i*N+j.
- overflow  out  1  sticky: some result of the current job saturated.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; accumulators, counters and buffers cleared. Asserting reset mid-job aborts the job; no done pulse is produced.
- FSM states: IDLE -> LOAD -> COMPUTE -> DRAIN -> IDLE.
- IDLE:
  - start=1 -> LOAD on the next edge.
  - Same edge: clear accumulators, load counter and overflow.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1; a word transfers when in_valid && in_ready.
  - Exactly 2*N*K words per job.
  - Words 0..N*K-1 are A, row-major: a[i][k] at i*K+k.
  - Words N*K..2*N*K-1 are B, filter-major: b[k][j] at N*K + j*K+k.
  - in_valid gaps stall the load with no other effect.
  - The edge accepting the final word -> COMPUTE.
- COMPUTE:
  - Lasts exactly K+2N-2 cycles, counted c = 0..K+2N-3.
  - PE(i,j) performs acc += a[i][k]*b[k][j] at cycle c = k+i+j for k in 0..K-1.
  - Skew is generated internally: row i feed delayed by i, column j feed delayed by j.
  - Zeros are fed outside the valid window.
  - After cycle K+2N-3 -> DRAIN.
- DRAIN:
  - Emits N*N results in index order 0..N*N-1.
  - out_data = min(acc >> SHIFT, 2^OUT_W - 1).
  - out_valid asserts in the first DRAIN cycle.
  - out_data and out_idx are held stable while out_valid && !out_ready.
  - Index advances on each handshake.
  - A saturating result sets overflow, which stays set until the next start.
  - The handshake of index N*N-1 -> IDLE, with done=1 and out_valid=0 in the following cycle.
- Arithmetic:
  - Unsigned throughout; product width 2*DATA_W, zero-extended to ACC_W.
  - The parameter check guarantees no accumulator wrap.
- Latency (no stalls): 1 + 2*N*K + (K+2N-2) + N*N cycles from start to done.

Decomposition:
- Package conv_engine_pkg:
  - state enum (IDLE, LOAD, COMPUTE, DRAIN);
  - saturate/shift function;
  - clog2-based width constants.
- Sub-module conv_pe: one MAC processing element with registered a/b pass-through (right and down), a clear input and an enable input; instantiated N*N times in a generate loop.

Test Plan (N=2, K=4, SHIFT=0 unless stated):
- A all 1, B all 2, ready always high -> outputs 8,8,8,8 at idx 0..3; overflow=0; done exactly 1+16+6+4=27 cycles after start.
- A=[1,2,3,4; 5,6,7,8], filter0=[1,0,0,0], filter1=[0,0,0,1] -> output sequence 1,4,5,8.
- A and B all 255 -> accumulator 260100; all outputs 255; overflow=1. Next job with all 1s -> overflow cleared on start, stays 0.
- out_ready low for 3 cycles while idx=1 is presented -> out_data and out_idx held for all 3 cycles; no result lost or duplicated.
- in_valid toggled 1,0,1,0 during LOAD plus start pulsed during COMPUTE -> results identical to the no-gap case; the extra start has no effect.
- rst asserted during COMPUTE cycle 3 -> outputs 0 immediately. A fresh job afterwards produces correct results, unaffected by the aborted partial sums.

Source files
------------

// File: rtl/conv_systolic_engine_pkg.sv
// conv_engine_pkg: FSM state type, width helper and result scaling shared by the convolution engine
package conv_engine_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  function automatic int width_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Shift the accumulator right, then clamp to the largest unsigned out_w-bit value.
  function automatic logic [63:0] sat_shift(input logic [63:0] acc, input int shift, input int out_w);
    logic [63:0] v, m;
    v = acc >> shift;
    m = (64'd1 << out_w) - 64'd1;
    return v > m ? m : v;
  endfunction
endpackage

// File: rtl/conv_systolic_engine_if.sv
// conv_systolic_engine_if: operand input stream and result output stream of the convolution engine
//   in_valid/in_ready/in_data     : operand words towards the engine
//   out_valid/out_ready/out_data  : saturated results from the engine
//   out_idx                       : result index i*N+j
//   slave modport = engine side, master modport = producer/consumer side
interface conv_systolic_engine_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W = 8,
  parameter int IDX_W = 2
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/conv_pe.sv
// conv_pe: output-stationary MAC cell with registered a (rightward) and b (downward) pass-through
//   clk, rst (async active-low), clr (zero all state), en (advance one MAC step)
//   a_in/b_in operands in, a_out/b_out delayed operands out, acc running sum
module conv_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);
  logic [2*DATA_W-1:0] prod;
  assign prod = a_in * b_in;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
      acc <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc <= acc + ACC_W'(prod);
    end
endmodule

// File: rtl/conv_systolic_engine.sv
// conv_systolic_engine: self-sequenced C = A(NxK) * B(KxN) on an NxN output-stationary systolic array
//   clk, rst (async active-low), start (sampled in IDLE)
//   busy (not IDLE), done (pulse after last result), overflow (sticky saturation flag for the job)
//   bus: operand stream in (2*N*K words, A row-major then B filter-major), results out in index order
module conv_systolic_engine
  import conv_engine_pkg::*;
#(
  parameter int N = 2,
  parameter int K = 9,
  parameter int DATA_W = 8,
  parameter int ACC_W = 20,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic overflow,
  conv_systolic_engine_if.slave bus
);
  localparam int NK = N * K;
  localparam int NN = N * N;
  localparam int AW = width_of(NK);
  localparam int IW = width_of(NN);
  localparam int CW = width_of(2 * NK);
  localparam logic [CW-1:0] LAST_WORD = CW'(2 * NK - 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(K + 2 * N - 3);
  localparam logic [IW-1:0] LAST_OUT = IW'(NN - 1);

  if (ACC_W < 2 * DATA_W + $clog2(K)) begin : g_acc_check
    $error("ACC_W too narrow for DATA_W and K");
  end

  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [IW-1:0] oidx;
  logic [DATA_W-1:0] a_buf [NK];
  logic [DATA_W-1:0] b_buf [NK];
  logic [DATA_W-1:0] a_feed [N];
  logic [DATA_W-1:0] b_feed [N];
  logic [DATA_W-1:0] a_h [N][N+1];
  logic [DATA_W-1:0] b_v [N+1][N];
  logic [ACC_W-1:0] acc [NN];
  logic [63:0] sat_val;
  logic in_fire, out_fire, clr, en, sat_hit;

  assign in_fire = state == LOAD && bus.in_valid;
  assign out_fire = state == DRAIN && bus.out_ready;
  assign clr = state == IDLE && start;
  assign en = state == COMPUTE;
  assign sat_val = sat_shift(64'(acc[oidx]), SHIFT, OUT_W);
  // A clamped value differs from the plain shifted accumulator.
  assign sat_hit = (64'(acc[oidx]) >> SHIFT) != sat_val;
  assign busy = state != IDLE;
  assign bus.in_ready = state == LOAD;
  assign bus.out_valid = state == DRAIN;
  assign bus.out_data = state == DRAIN ? OUT_W'(sat_val) : '0;
  assign bus.out_idx = oidx;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nstate;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = start ? LOAD : IDLE;
      LOAD:    nstate = in_fire && cnt == LAST_WORD ? COMPUTE : LOAD;
      COMPUTE: nstate = cnt == LAST_CYC ? DRAIN : COMPUTE;
      DRAIN:   nstate = out_fire && oidx == LAST_OUT ? IDLE : DRAIN;
      default: nstate = IDLE;
    endcase
  end

  // Skewed edge feeds: at compute cycle c, row i carries a[i][c-i] and column j carries b[c-j][j];
  // zeros outside the valid window. Buffer layouts a[i*K+k] and b[j*K+k] share the same index form.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i] = '0;
      b_feed[i] = '0;
      if (state == COMPUTE && int'(cnt) >= i && int'(cnt) < i + K) begin
        a_feed[i] = a_buf[AW'(i * K + int'(cnt) - i)];
        b_feed[i] = b_buf[AW'(i * K + int'(cnt) - i)];
      end
    end
  end

  // cnt counts accepted words in LOAD and compute cycles in COMPUTE; it is back at 0 on each transition.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      oidx <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
      for (int n = 0; n < NK; n++) begin
        a_buf[n] <= '0;
        b_buf[n] <= '0;
      end
    end else begin
      done <= out_fire && oidx == LAST_OUT;
      if (clr) begin
        cnt <= '0;
        oidx <= '0;
        overflow <= 1'b0;
      end
      if (in_fire) begin
        cnt <= cnt == LAST_WORD ? '0 : cnt + 1'b1;
        if (cnt < CW'(NK)) a_buf[AW'(cnt)] <= bus.in_data;
        else b_buf[AW'(cnt - CW'(NK))] <= bus.in_data;
      end
      if (state == COMPUTE) cnt <= cnt == LAST_CYC ? '0 : cnt + 1'b1;
      if (out_fire) begin
        oidx <= oidx == LAST_OUT ? '0 : oidx + 1'b1;
        overflow <= overflow | sat_hit;
      end
    end

  for (genvar i = 0; i < N; i++) begin : g_row
    assign a_h[i][0] = a_feed[i];
    assign b_v[0][i] = b_feed[i];
    for (genvar j = 0; j < N; j++) begin : g_col
      conv_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .en(en),
        .a_in(a_h[i][j]),
        .b_in(b_v[i][j]),
        .a_out(a_h[i][j+1]),
        .b_out(b_v[i+1][j]),
        .acc(acc[i*N+j])
      );
    end
  end
endmodule

// File: tb/tb_conv_systolic_engine.sv
// tb_conv_systolic_engine: table-driven jobs plus stall, gap, spurious-start and reset-abort sequences
module tb_conv_systolic_engine;
  localparam int N = 2;
  localparam int K = 4;
  localparam int NK = N * K;
  localparam int NN = N * N;

  typedef struct packed {
    logic [15:0][7:0] w;
    logic [3:0][7:0] exp;
    logic ovf;
    logic gaps;
    logic stall;
    logic mids;
  } job_t;

  logic clk, rst, start, busy, done, overflow;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  job_t jobs [7];

  conv_systolic_engine_if #(.DATA_W(8), .OUT_W(8), .IDX_W(2)) bus ();

  conv_systolic_engine #(
    .N(N), .K(K), .DATA_W(8), .ACC_W(20), .OUT_W(8), .SHIFT(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic job_t mk(input logic [63:0] a, input logic [63:0] b, input logic [31:0] e,
                              input logic [3:0] f);
    job_t j;
    j.w = {b, a};
    j.exp = e;
    {j.ovf, j.gaps, j.stall, j.mids} = f;
    return j;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a negedge with the engine in LOAD; returns at the negedge after the last word.
  task automatic load_words(input job_t j, input string tag);
    int w, guard;
    logic tog;
    w = 0;
    guard = 0;
    tog = 1'b1;
    while (w < 2 * NK && guard < 200) begin
      bus.in_valid = j.gaps ? tog : 1'b1;
      tog = !tog;
      bus.in_data = j.w[w[3:0]];
      if (bus.in_valid && bus.in_ready) w++;
      guard++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({tag, " words_loaded"}, w, 2 * NK);
  endtask

  task automatic run_job(input job_t j, input string tag);
    int got, guard, stall_left, c0;
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, " load_entry{busy,in_ready,overflow}"}, {busy, bus.in_ready, overflow}, 3'b110);
    load_words(j, tag);
    if (j.mids) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 0;
    guard = 0;
    stall_left = j.stall ? 3 : 0;
    while (got < NN && guard < 200) begin
      bus.out_ready = !(stall_left > 0 && bus.out_valid && bus.out_idx == 2'd1);
      if (!bus.out_ready) begin
        check({tag, " stall_hold{idx,data}"}, {bus.out_idx, bus.out_data}, {2'd1, j.exp[1]});
        stall_left--;
      end else if (bus.out_valid) begin
        check($sformatf("%s out_idx[%0d]", tag, got), bus.out_idx, got);
        check($sformatf("%s out_data[%0d]", tag, got), bus.out_data, j.exp[got[1:0]]);
        got++;
      end
      guard++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check({tag, " results_drained"}, got, NN);
    if (j.stall) check({tag, " stall_cycles_used"}, stall_left, 0);
    check({tag, " done{done,out_valid}"}, {done, bus.out_valid}, 2'b10);
    check({tag, " overflow"}, overflow, j.ovf);
    if (!j.gaps && !j.stall && !j.mids) check({tag, " latency"}, cyc - c0, 1 + 2 * NK + K + 2 * N - 2 + NN);
    @(negedge clk);
    check({tag, " idle{done,busy}"}, {done, busy}, 2'b00);
  endtask

  initial begin
    jobs[0] = mk(64'h0101010101010101, 64'h0202020202020202, 32'h08080808, 4'b0000);
    jobs[1] = mk(64'h0807060504030201, 64'h0100000000000001, 32'h08050401, 4'b0000);
    jobs[2] = mk(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 4'b1000);
    jobs[3] = mk(64'h0101010101010101, 64'h0101010101010101, 32'h04040404, 4'b0000);
    jobs[4] = mk(64'h0807060504030201, 64'h0100000000000001, 32'h08050401, 4'b0010);
    jobs[5] = mk(64'h0807060504030201, 64'h0100000000000001, 32'h08050401, 4'b0101);
    jobs[6] = mk(64'h0807060504030201, 64'h0403020101010101, 32'h461A1E0A, 4'b0000);
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    #1;
    check("reset{busy,done,ovf,in_rdy,out_vld}", {busy, done, overflow, bus.in_ready, bus.out_valid}, 5'b0);
    check("reset{out_idx,out_data}", {bus.out_idx, bus.out_data}, 10'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 7; t++) run_job(jobs[t], $sformatf("job%0d", t));
    // Abort a job in compute cycle 3, then confirm a fresh job is unaffected.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_words(jobs[2], "abort");
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort{busy,done,ovf,in_rdy,out_vld}", {busy, done, overflow, bus.in_ready, bus.out_valid}, 5'b0);
    check("abort{out_idx,out_data}", {bus.out_idx, bus.out_data}, 10'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_done{done,busy}", {done, busy}, 2'b00);
    run_job(jobs[6], "post_abort");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
